// File: rtl/sr_button_sequencer_if.sv
// Command bus between the button sequencer and the downstream SR flip-flop.
//   sr_out    : {S,R} command, 00 hold / 10 set / 01 reset
//   cmd_valid : high for exactly the cycle sr_out is non-zero
//   q_fb      : q output of the flip-flop, read back for verification
// master = sequencer side, slave = flip-flop side.
interface sr_button_sequencer_if;
    logic [1:0] sr_out;
    logic       cmd_valid;
    logic       q_fb;

    modport master (
        output sr_out,
        output cmd_valid,
        input  q_fb
    );

    modport slave (
        input  sr_out,
        input  cmd_valid,
        output q_fb
    );
endinterface

// File: rtl/sr_button_sequencer.sv
// Upstream command stage for an SR flip-flop.
// Two raw push-buttons (set, reset) are synchronised, debounced and edge
// detected. Each press becomes a one-cycle {S,R} command on the bus. The
// illegal 11 code is never produced. The flip-flop's q is read back one
// cycle after each command, and any command that did not take effect is
// flagged.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high reset
//   set_btn  : raw asynchronous set button, active-high
//   rst_btn  : raw asynchronous reset button, active-high
//   cmd      : command bus (sr_out, cmd_valid out; q_fb in)
//   busy     : sequencer not idle
//   conflict : one-cycle pulse when set and reset were resolved together
//   mismatch : sticky flag, q_fb differed from the commanded value
module sr_button_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        set_btn,
    input  logic                        rst_btn,
    sr_button_sequencer_if.master       cmd,
    output logic                        busy,
    output logic                        conflict,
    output logic                        mismatch
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Button index 0 is set, index 1 is reset.
    localparam int SET_IDX = 0;
    localparam int RST_IDX = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]            btn_raw_s;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            stable_q, stable_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            rise_s;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            clr_pend_s;

    state_e                state_q, state_d;
    logic                  exp_q, exp_d;
    logic [1:0]            sr_out_q, sr_out_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  busy_q, busy_d;
    logic                  conflict_q, conflict_d;
    logic                  mismatch_q, mismatch_d;

    assign btn_raw_s = {rst_btn, set_btn};

    // Synchroniser, debounce counter and stable-value update for both buttons.
    always_comb begin
        sync1_d  = btn_raw_s;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_s   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                // Counter counts edges of disagreement; the edge that completes
                // the count both flips the stable value and rearms the counter.
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = {CNT_W{1'b0}};
                    rise_s[i]   = sync2_q[i];
                end else begin
                    cnt_d[i]    = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = {CNT_W{1'b0}};
            end
        end
    end

    // Pending flags: a new rise sets the flag even on the edge the FSM clears it.
    always_comb begin
        pend_d = (pend_q & ~clr_pend_s) | rise_s;
    end

    // FSM next state and registered-output values.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        sr_out_d    = 2'b00;
        cmd_valid_d = 1'b0;
        conflict_d  = 1'b0;
        mismatch_d  = mismatch_q;
        clr_pend_s  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (pend_q[RST_IDX]) begin
                    state_d             = ST_ISSUE;
                    exp_d               = 1'b0;
                    sr_out_d            = 2'b01;
                    cmd_valid_d         = 1'b1;
                    clr_pend_s[RST_IDX] = 1'b1;
                    // Reset wins a tie; the set request is dropped, not deferred.
                    if (pend_q[SET_IDX]) begin
                        clr_pend_s[SET_IDX] = 1'b1;
                        conflict_d          = 1'b1;
                    end else begin
                        conflict_d          = 1'b0;
                    end
                end else if (pend_q[SET_IDX]) begin
                    state_d             = ST_ISSUE;
                    exp_d               = 1'b1;
                    sr_out_d            = 2'b10;
                    cmd_valid_d         = 1'b1;
                    clr_pend_s[SET_IDX] = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Flip-flop samples the command at the end of this cycle.
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cmd.q_fb != exp_q) begin
                    mismatch_d = 1'b1;
                end else begin
                    mismatch_d = mismatch_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            stable_q    <= 2'b00;
            cnt_q       <= '0;
            pend_q      <= 2'b00;
            state_q     <= ST_IDLE;
            exp_q       <= 1'b0;
            sr_out_q    <= 2'b00;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            conflict_q  <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            state_q     <= state_d;
            exp_q       <= exp_d;
            sr_out_q    <= sr_out_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            conflict_q  <= conflict_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign cmd.sr_out    = sr_out_q;
    assign cmd.cmd_valid = cmd_valid_q;
    assign busy          = busy_q;
    assign conflict      = conflict_q;
    assign mismatch      = mismatch_q;

endmodule

// File: tb/tb_sr_button_sequencer.sv
// Directed bench for sr_button_sequencer with DEBOUNCE_CYCLES=4.
// Edge k below is the k-th rising edge after the button was driven; outputs
// are sampled 1 ns after each rising edge. A behavioural SR flip-flop sits on
// the bus and can be forced to read back 0.
module tb_sr_button_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic set_btn;
    logic rst_btn;
    logic busy;
    logic conflict;
    logic mismatch;
    logic tie_q0;
    logic q_ff = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sr_button_sequencer_if cmd_if ();

    sr_button_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .set_btn  (set_btn),
        .rst_btn  (rst_btn),
        .cmd      (cmd_if.master),
        .busy     (busy),
        .conflict (conflict),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // Downstream SR flip-flop model.
    always @(posedge clk) begin
        if (cmd_if.sr_out == 2'b10) q_ff <= 1'b1;
        else if (cmd_if.sr_out == 2'b01) q_ff <= 1'b0;
    end
    assign cmd_if.q_fb = tie_q0 ? 1'b0 : q_ff;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int nv;
        logic [1:0] exp_sr;

        reset = 1'b1; set_btn = 1'b0; rst_btn = 1'b0; tie_q0 = 1'b0;
        tick(3);
        check_eq("rst_sr",       {6'd0, cmd_if.sr_out},    8'd0);
        check_eq("rst_valid",    {7'd0, cmd_if.cmd_valid}, 8'd0);
        check_eq("rst_busy",     {7'd0, busy},             8'd0);
        check_eq("rst_conflict", {7'd0, conflict},         8'd0);
        check_eq("rst_mismatch", {7'd0, mismatch},         8'd0);
        reset = 1'b0;
        tick(2);

        // 1: clean set press, command only after edge 7.
        set_btn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            exp_sr = (k == 7) ? 2'b10 : 2'b00;
            check_eq($sformatf("t1_sr_k%0d", k),    {6'd0, cmd_if.sr_out},    {6'd0, exp_sr});
            check_eq($sformatf("t1_valid_k%0d", k), {7'd0, cmd_if.cmd_valid}, {7'd0, (k == 7)});
            check_eq($sformatf("t1_busy_k%0d", k),  {7'd0, busy},             {7'd0, (k == 7 || k == 8)});
        end
        set_btn = 1'b0;
        check_eq("t1_mismatch", {7'd0, mismatch}, 8'd0);
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (cmd_if.cmd_valid) nv++;
        end
        check_eq("t1_release_quiet", nv[7:0], 8'd0);

        // 2: 3-cycle glitch is filtered; a following clean press keeps full latency.
        set_btn = 1'b1;
        tick(3);
        set_btn = 1'b0;
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (cmd_if.cmd_valid) nv++;
        end
        check_eq("t2_glitch_quiet", nv[7:0], 8'd0);
        set_btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check_eq($sformatf("t2_valid_k%0d", k), {7'd0, cmd_if.cmd_valid}, {7'd0, (k == 7)});
        end
        set_btn = 1'b0;
        tick(12);

        // 3: simultaneous presses -> one reset command, conflict pulse, no set.
        set_btn = 1'b1;
        rst_btn = 1'b1;
        nv = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            exp_sr = (k == 7) ? 2'b01 : 2'b00;
            if (cmd_if.sr_out == 2'b10) nv++;
            check_eq($sformatf("t3_sr_k%0d", k),       {6'd0, cmd_if.sr_out}, {6'd0, exp_sr});
            check_eq($sformatf("t3_conflict_k%0d", k), {7'd0, conflict},      {7'd0, (k == 7)});
        end
        check_eq("t3_no_set", nv[7:0], 8'd0);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        tick(12);

        // 4: set command that does not take effect -> sticky mismatch.
        tie_q0 = 1'b1;
        set_btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check_eq($sformatf("t4_mismatch_k%0d", k), {7'd0, mismatch}, {7'd0, (k >= 9)});
        end
        set_btn = 1'b0;
        tick(12);
        tie_q0 = 1'b0;
        rst_btn = 1'b1;
        tick(10);
        rst_btn = 1'b0;
        tick(12);
        check_eq("t4_sticky", {7'd0, mismatch}, 8'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("t4_cleared", {7'd0, mismatch}, 8'd0);
        tick(2);

        // 5: reset during ISSUE aborts the command; nothing follows.
        set_btn = 1'b1;
        tick(7);
        check_eq("t5_issue_sr", {6'd0, cmd_if.sr_out}, 8'h02);
        reset = 1'b1;
        set_btn = 1'b0;
        tick(1);
        check_eq("t5_sr",    {6'd0, cmd_if.sr_out},    8'd0);
        check_eq("t5_valid", {7'd0, cmd_if.cmd_valid}, 8'd0);
        check_eq("t5_busy",  {7'd0, busy},             8'd0);
        reset = 1'b0;
        nv = 0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (cmd_if.cmd_valid) nv++;
        end
        check_eq("t5_no_cmd", nv[7:0], 8'd0);

        // 6: reset press lands while the set command is in CHECK -> 01 at edge 10.
        set_btn = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            exp_sr = (k == 7) ? 2'b10 : ((k == 10) ? 2'b01 : 2'b00);
            check_eq($sformatf("t6_sr_k%0d", k), {6'd0, cmd_if.sr_out}, {6'd0, exp_sr});
            if (k == 3) rst_btn = 1'b1;
        end
        check_eq("t6_mismatch", {7'd0, mismatch}, 8'd0);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
